// File: rtl/standard_7448.sv
// BCD-to-seven-segment decoder in the style of the 7448, with registered
// active-high segment outputs plus lamp-test and ripple-blanking controls.
`timescale 1ns/1ps

module standard_7448 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data,
    input  logic       LT,
    input  logic       RBI,
    input  logic       BI,
    output logic [6:0] display,
    output logic       RBO
);

    logic [6:0] display_q, display_d;
    logic       rbo_q, rbo_d;
    logic [6:0] glyph;

    // Segment order {a,b,c,d,e,f,g}; codes 10-15 use the 7448 glyph set.
    always_comb begin
        glyph = 7'h00;
        case (data)
            4'd0:  glyph = 7'h7E;
            4'd1:  glyph = 7'h30;
            4'd2:  glyph = 7'h6D;
            4'd3:  glyph = 7'h79;
            4'd4:  glyph = 7'h33;
            4'd5:  glyph = 7'h5B;
            4'd6:  glyph = 7'h1F;
            4'd7:  glyph = 7'h70;
            4'd8:  glyph = 7'h7F;
            4'd9:  glyph = 7'h73;
            4'd10: glyph = 7'h0D;
            4'd11: glyph = 7'h19;
            4'd12: glyph = 7'h23;
            4'd13: glyph = 7'h4B;
            4'd14: glyph = 7'h0F;
            4'd15: glyph = 7'h00;
            default: glyph = 7'h00;
        endcase
    end

    // Priority BI > LT > RBI-on-zero > normal decode.
    always_comb begin
        display_d = glyph;
        rbo_d     = 1'b0;
        if (BI) begin
            display_d = 7'h00;
        end else if (LT) begin
            display_d = 7'h7F;
        end else if (RBI && (data == 4'd0)) begin
            display_d = 7'h00;
            rbo_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_q <= 7'h00;
            rbo_q     <= 1'b0;
        end else begin
            display_q <= display_d;
            rbo_q     <= rbo_d;
        end
    end

    assign display = display_q;
    assign RBO     = rbo_q;

endmodule

// File: tb/tb_standard_7448.sv
// Scoreboard bench for standard_7448: expected {display,RBO} pushed when the
// inputs are driven, popped and compared one clock later.
`timescale 1ns/1ps

module tb_standard_7448;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] data = 4'd0;
    logic       LT = 1'b0;
    logic       RBI = 1'b0;
    logic       BI = 1'b0;
    logic [6:0] display;
    logic       RBO;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_v;

    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h1F, 7'h70,
        7'h7F, 7'h73, 7'h0D, 7'h19, 7'h23, 7'h4B, 7'h0F, 7'h00
    };

    standard_7448 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .LT      (LT),
        .RBI     (RBI),
        .BI      (BI),
        .display (display),
        .RBO     (RBO)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_out(input logic [3:0] d, input logic lt,
                                           input logic rbi, input logic bi);
        if (bi)                   return 8'h00;
        if (lt)                   return {7'h7F, 1'b0};
        if (rbi && d == 4'd0)     return {7'h00, 1'b1};
        return {GLYPH[d], 1'b0};
    endfunction

    // Drive inputs at the falling edge, queue expectation, settle after the rising edge.
    task automatic step(input logic [3:0] d, input logic lt, input logic rbi, input logic bi);
        @(negedge clk);
        data = d; LT = lt; RBI = rbi; BI = bi;
        sb.push_back(ref_out(d, lt, rbi, bi));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data = 4'd8; LT = 1'b1; RBI = 1'b0; BI = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({display, RBO} !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: got display=%h RBO=%b, want display=00 RBO=0", display, RBO);
        end
        $display("reset_hold: display=%h RBO=%b", display, RBO);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd8, 1'b0, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if ({display, RBO} !== exp_v || display !== 7'h7F) begin
            errors++;
            $display("FAIL reset_release: got %h/%b, want %h/%b", display, RBO, exp_v[7:1], exp_v[0]);
        end
        $display("reset_release: display=%h RBO=%b", display, RBO);
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            step(4'(i), 1'b0, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if ({display, RBO} !== {GLYPH[i], 1'b0} || {display, RBO} !== exp_v) begin
                errors++;
                $display("FAIL sweep data=%0d: got %h/%b, want %h/0", i, display, RBO, GLYPH[i]);
            end
            $display("sweep data=%0d: display=%h RBO=%b", i, display, RBO);
        end
    endtask

    task automatic test_lamp();
        step(4'd4, 1'b1, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if ({display, RBO} !== exp_v) begin
            errors++;
            $display("FAIL lamp_on: got %h/%b, want %h/%b", display, RBO, exp_v[7:1], exp_v[0]);
        end
        $display("lamp_on: display=%h RBO=%b", display, RBO);
        step(4'd4, 1'b0, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if ({display, RBO} !== exp_v) begin
            errors++;
            $display("FAIL lamp_off: got %h/%b, want %h/%b", display, RBO, exp_v[7:1], exp_v[0]);
        end
        $display("lamp_off: display=%h RBO=%b", display, RBO);
    endtask

    task automatic test_ripple();
        step(4'd0, 1'b0, 1'b1, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if ({display, RBO} !== exp_v) begin
            errors++;
            $display("FAIL ripple_zero: got %h/%b, want %h/%b", display, RBO, exp_v[7:1], exp_v[0]);
        end
        $display("ripple_zero: display=%h RBO=%b", display, RBO);
        step(4'd3, 1'b0, 1'b1, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if ({display, RBO} !== exp_v) begin
            errors++;
            $display("FAIL ripple_nonzero: got %h/%b, want %h/%b", display, RBO, exp_v[7:1], exp_v[0]);
        end
        $display("ripple_nonzero: display=%h RBO=%b", display, RBO);
    endtask

    task automatic test_blank_priority();
        step(4'd2, 1'b1, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if ({display, RBO} !== exp_v) begin
            errors++;
            $display("FAIL blank_all: got %h/%b, want %h/%b", display, RBO, exp_v[7:1], exp_v[0]);
        end
        $display("blank_all: display=%h RBO=%b", display, RBO);
        step(4'd2, 1'b1, 1'b1, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if ({display, RBO} !== exp_v) begin
            errors++;
            $display("FAIL blank_release: got %h/%b, want %h/%b", display, RBO, exp_v[7:1], exp_v[0]);
        end
        $display("blank_release: display=%h RBO=%b", display, RBO);
        // BI with zero data and RBI must not raise RBO.
        step(4'd0, 1'b0, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if ({display, RBO} !== exp_v) begin
            errors++;
            $display("FAIL blank_zero: got %h/%b, want %h/%b", display, RBO, exp_v[7:1], exp_v[0]);
        end
        $display("blank_zero: display=%h RBO=%b", display, RBO);
    endtask

    task automatic test_latency();
        step(4'd1, 1'b0, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        #2;
        data = 4'd7;
        sb.push_back(ref_out(4'd7, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checks++;
        if (display !== 7'h30 || exp_v[7:1] !== 7'h30) begin
            errors++;
            $display("FAIL latency_hold: got %h, want 30", display);
        end
        $display("latency_hold: display=%h RBO=%b", display, RBO);
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if ({display, RBO} !== exp_v) begin
            errors++;
            $display("FAIL latency_update: got %h/%b, want %h/%b", display, RBO, exp_v[7:1], exp_v[0]);
        end
        $display("latency_update: display=%h RBO=%b", display, RBO);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            step(4'($urandom_range(15)), 1'($urandom_range(3) == 0),
                 1'($urandom_range(1)), 1'($urandom_range(4) == 0));
            exp_v = sb.pop_front();
            checks++;
            if ({display, RBO} !== exp_v) begin
                errors++;
                $display("FAIL random[%0d] d=%0d LT=%b RBI=%b BI=%b: got %h/%b, want %h/%b",
                         i, data, LT, RBI, BI, display, RBO, exp_v[7:1], exp_v[0]);
            end
            $display("random[%0d] d=%0d LT=%b RBI=%b BI=%b: display=%h RBO=%b",
                     i, data, LT, RBI, BI, display, RBO);
        end
    endtask

    task automatic test_async_reset();
        step(4'd8, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({display, RBO} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %h/%b, want 00/0", display, RBO);
        end
        $display("async_reset: display=%h RBO=%b", display, RBO);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd0, 1'b0, 1'b1, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if ({display, RBO} !== exp_v) begin
            errors++;
            $display("FAIL after_reset: got %h/%b, want %h/%b", display, RBO, exp_v[7:1], exp_v[0]);
        end
        $display("after_reset: display=%h RBO=%b", display, RBO);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_lamp();
        test_ripple();
        test_blank_priority();
        test_latency();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
